// File: rtl/seg_digit_scanner_if.sv
// Display-side bundle between the digit scanner and its host/decoder.
// master drives value/dp_in/en; slave (the scanner) drives an/digit/dp/frame_start.
interface seg_digit_scanner_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        en;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dp;
  logic        frame_start;

  modport master (
    output value, dp_in, en,
    input  an, digit, dp, frame_start
  );

  modport slave (
    input  value, dp_in, en,
    output an, digit, dp, frame_start
  );
endinterface

// File: rtl/seg_digit_scanner.sv
// Four-digit common-anode scanner with per-frame snapshot and anti-ghosting gap.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_digit_scanner #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int DIGIT_HZ   = 1000,
  parameter int GAP_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_digit_scanner_if.slave   bus
);

  localparam int DIV   = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2 || GAP_CYCLES < 0 || GAP_CYCLES >= DIV) begin : g_bad_params
      $error("seg_digit_scanner: need DIV >= 2 and 0 <= GAP_CYCLES < DIV");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_snap_val;
  logic [3:0]       r_snap_dp;
  logic [3:0]       r_an;
  logic [3:0]       r_digit;
  logic             r_dp;
  logic             r_frame_start;

  logic             w_frame_edge;
  logic             w_cnt_wrap;
  logic [15:0]      w_sv;
  logic [3:0]       w_sdp;
  logic             w_gap;
  logic             w_blank;
  logic             w_drive;
  logic [3:0]       w_an_next;
  logic [3:0]       w_digit_next;
  logic             w_dp_next;

  // r_cnt/r_idx name the slot position the coming edge presents, so the
  // first edge out of reset is cycle 0 of slot 0.
  assign w_frame_edge = (r_cnt == '0) && (r_idx == 2'd0);
  assign w_cnt_wrap   = (r_cnt == CNT_W'(DIV - 1));

  // On the snapshot edge the fresh inputs are used directly so slot 0
  // shows the new nibble from its very first cycle.
  assign w_sv  = w_frame_edge ? bus.value : r_snap_val;
  assign w_sdp = w_frame_edge ? bus.dp_in : r_snap_dp;

  generate
    if (GAP_CYCLES == 0) begin : g_no_gap
      assign w_gap = 1'b0;
    end else begin : g_gap
      assign w_gap = (r_cnt < CNT_W'(GAP_CYCLES));
    end
  endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [3:0] w_lead_zero;
  assign w_lead_zero[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
    assign w_lead_zero[gi] = (w_sv[15:4*gi] == '0);
  end
  assign w_blank = w_lead_zero[r_idx] & ~w_sdp[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  assign w_drive = ~w_gap & bus.en & ~w_blank;

  always_comb begin
    w_an_next    = 4'b1111;
    w_dp_next    = 1'b1;
    w_digit_next = w_sv[{r_idx, 2'b00} +: 4];
    if (w_drive) begin
      w_an_next = ~(4'b0001 << r_idx);
      w_dp_next = ~w_sdp[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_snap_val    <= 16'h0000;
      r_snap_dp     <= 4'h0;
      r_an          <= 4'b1111;
      r_digit       <= 4'h0;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      if (w_cnt_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_frame_edge) begin
        r_snap_val <= bus.value;
        r_snap_dp  <= bus.dp_in;
      end
      r_an          <= w_an_next;
      r_digit       <= w_digit_next;
      r_dp          <= w_dp_next;
      r_frame_start <= w_frame_edge;
    end
  end

  assign bus.an          = r_an;
  assign bus.digit       = r_digit;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Randomized self-checking bench for seg_digit_scanner against a cycle-count model.
// Build with or without SEG_LEADING_ZERO_BLANK_EN; the model follows the same macro.
module tb_seg_digit_scanner;
  localparam int CLK_HZ   = 1000;
  localparam int DIGIT_HZ = 100;
  localparam int GAP      = 2;
  localparam int DIV      = CLK_HZ / DIGIT_HZ;
  localparam int FRAME    = 4 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   t = -1;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_sdp  = 4'h0;

  seg_digit_scanner_if bus_if();

  seg_digit_scanner #(
    .CLK_HZ(CLK_HZ), .DIGIT_HZ(DIGIT_HZ), .GAP_CYCLES(GAP)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
    end
  endtask

  // One clock: advance the model by absolute cycle number, then compare all outputs.
  task automatic tick();
    int slot, ph;
    logic [15:0] upper;
    logic blank, drive;
    logic [3:0] e_an, e_digit;
    logic e_dp, e_fs;
    @(posedge clk);
    if (rst) begin
      t = -1;
    end else begin
      t++;
      if (t % FRAME == 0) begin
        m_snap = bus_if.value;
        m_sdp  = bus_if.dp_in;
      end
    end
    #1;
    if (t < 0) begin
      e_an = 4'b1111; e_digit = 4'h0; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      slot    = (t / DIV) % 4;
      ph      = t % DIV;
      upper   = m_snap >> (4 * slot);
      e_digit = upper[3:0];
      blank   = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      blank   = (slot != 0) && (upper == 16'h0) && !m_sdp[slot];
`endif
      drive   = (ph >= GAP) && bus_if.en && !blank;
      e_an    = drive ? ~(4'b0001 << slot) : 4'b1111;
      e_dp    = drive ? ~m_sdp[slot] : 1'b1;
      e_fs    = (t % FRAME == 0);
    end
    check("an", {12'h0, bus_if.an}, {12'h0, e_an});
    check("digit", {12'h0, bus_if.digit}, {12'h0, e_digit});
    check("dp", {15'h0, bus_if.dp}, {15'h0, e_dp});
    check("frame_start", {15'h0, bus_if.frame_start}, {15'h0, e_fs});
    check("one_anode", {15'h0, ($countones(~bus_if.an) <= 1)}, 16'h1);
    $display("cyc t=%0d rst=%0b val=%h en=%0b an=%b digit=%h dp=%0b fs=%0b",
             t, rst, bus_if.value, bus_if.en, bus_if.an, bus_if.digit, bus_if.dp, bus_if.frame_start);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus_if.value = 16'hFFFF;
    bus_if.dp_in = 4'h0;
    bus_if.en    = 1'b1;

    // Held reset: outputs stay at reset values.
    rst = 1'b1;
    repeat (3) tick();

    // 0x1234 with mid-frame change to 0xABCD ahead of cycle 15.
    bus_if.value = 16'h1234;
    bus_if.dp_in = 4'b0010;
    rst = 1'b0;
    for (int c = 0; c < 85; c++) begin
      if (c == 15) bus_if.value = 16'hABCD;
      tick();
      if (t == 1)  check("gap_an", {12'h0, bus_if.an}, 16'h000F);
      if (t == 2)  check("slot0_an", {12'h0, bus_if.an}, 16'h000E);
      if (t == 12) check("slot1_digit", {12'h0, bus_if.digit}, 16'h0003);
      if (t == 12) check("slot1_dp", {15'h0, bus_if.dp}, 16'h0000);
      if (t == 25) check("slot2_old_digit", {12'h0, bus_if.digit}, 16'h0002);
      if (t == 32) check("slot3_an", {12'h0, bus_if.an}, 16'h0007);
      if (t == 40) check("new_frame_digit", {12'h0, bus_if.digit}, 16'h000D);
      if (t == 75) check("slot3_new_digit", {12'h0, bus_if.digit}, 16'h000A);
      if (t == 80) check("frame_start_80", {15'h0, bus_if.frame_start}, 16'h0001);
    end

    // en low for cycles 5..25.
    bus_if.value = 16'h1234;
    pulse_reset();
    for (int c = 0; c < 45; c++) begin
      bus_if.en = !(c >= 5 && c <= 25);
      tick();
      if (t == 15) check("en_off_an", {12'h0, bus_if.an}, 16'h000F);
      if (t == 26) check("en_back_an", {12'h0, bus_if.an}, 16'h000B);
    end
    bus_if.en = 1'b1;

    // Reset pulse after cycle 23.
    pulse_reset();
    for (int c = 0; c < 24; c++) tick();
    pulse_reset();
    tick();
    check("restart_fs", {15'h0, bus_if.frame_start}, 16'h0001);
    check("restart_digit", {12'h0, bus_if.digit}, 16'h0004);

    // Leading-zero value, without and with a dp request on digit 2.
    bus_if.value = 16'h0050;
    bus_if.dp_in = 4'h0;
    pulse_reset();
    for (int c = 0; c < 40; c++) begin
      tick();
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (t == 35) check("lz_slot3_an", {12'h0, bus_if.an}, 16'h000F);
`else
      if (t == 35) check("lz_slot3_an", {12'h0, bus_if.an}, 16'h0007);
`endif
      if (t == 15) check("lz_slot1_an", {12'h0, bus_if.an}, 16'h000D);
    end
    bus_if.dp_in = 4'b0100;
    pulse_reset();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (t == 25) check("lz_dp_slot2_an", {12'h0, bus_if.an}, 16'h000B);
    end

    // Randomized run with sparse leading-zero values, en toggles and resets.
    bus_if.dp_in = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0)
        bus_if.value = 16'($urandom() >> $urandom_range(31, 16));
      if ($urandom_range(9) == 0) bus_if.en = ~bus_if.en;
      if ($urandom_range(15) == 0) bus_if.dp_in = 4'($urandom());
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
